// File: rtl/spm_seq_ctrl.sv
// spm_seq_ctrl: loads an operand pair, clears the spm array, streams the multiplier LSB-first and collects the product
module spm_seq_ctrl #(
  parameter int WIDTH    = 32,
  parameter int PIPE_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a_in,
  input  logic [WIDTH-1:0]     b_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic [WIDTH-1:0]     spm_x,
  output logic                 spm_y,
  output logic                 spm_clr,
  input  logic                 spm_p
);
  localparam int N  = 2*WIDTH + PIPE_LAT;
  localparam int CW = $clog2(N + 1);
  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;
  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d, rel;
  logic [WIDTH-1:0]   x_q, x_d, b_sh_q, b_sh_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic               accept, last, cap;
  always_comb begin
    accept  = state_q == IDLE && in_valid;
    last    = cnt_q == CW'(N - 1);
    rel     = cnt_q - CW'(PIPE_LAT);
    cap     = state_q == RUN && rel < CW'(2*WIDTH);
    state_d = state_q == IDLE  ? (in_valid ? CLEAR : IDLE) :
              state_q == CLEAR ? RUN :
              state_q == RUN   ? (last ? DONE : RUN) :
                                 (out_ready ? IDLE : DONE);
    cnt_d   = state_q == RUN ? cnt_q + 1'b1 : '0;
    x_d     = accept ? a_in : x_q;
    b_sh_d  = accept ? b_in : state_q == RUN ? b_sh_q >> 1 : b_sh_q;
    prod_d  = accept ? '0 : cap ? {spm_p, prod_q[2*WIDTH-1:1]} : prod_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      b_sh_q  <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      b_sh_q  <= b_sh_d;
      prod_q  <= prod_d;
    end
  end
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE && !rst;
  assign spm_clr   = state_q == CLEAR || rst;
  assign spm_y     = !rst && state_q == RUN && cnt_q < CW'(WIDTH) && b_sh_q[0];
  assign spm_x     = x_q;
  assign product   = prod_q;
endmodule
